// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle sequencer: FSM state encoding,
// the opcodes the sequencer recognises, fault cause codes and the reset
// value of the instruction register.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    EXECUTE    = 3'd3,
    MEM_REQ    = 3'd4,
    MEM_WAIT   = 3'd5,
    WRITEBACK  = 3'd6,
    FAULT      = 3'd7
  } state_t;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] CAUSE_NONE        = 2'd0;
  localparam logic [1:0] CAUSE_BUS_TIMEOUT = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'd2;
  localparam logic [1:0] CAUSE_MISALIGNED  = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    return (op == OP_REG)  || (op == OP_IMM)   || (op == OP_JALR) ||
           (op == OP_LUI)  || (op == OP_AUIPC) || (op == OP_JAL)  ||
           (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_mem_opcode(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus wait watchdog. Loaded when a wait state is entered and counted down
// once per cycle spent waiting; 'expired' flags the last permitted wait
// cycle so the FSM can fault if no response shows up in that cycle.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clear       reload (asserted on the cycle a request is accepted)
//   count       decrement (asserted while in a wait state)
//   expired     this wait cycle is the MEM_TIMEOUT-th one
module bus_watchdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  // First wait cycle sees RELOAD; the MEM_TIMEOUT-th sees zero.
  localparam logic [CW-1:0] RELOAD = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] remaining;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= '0;
    end else if (clear) begin
      remaining <= RELOAD;
    end else if (count && (remaining != '0)) begin
      remaining <= remaining - CW'(1);
    end
  end

  assign expired = count && (remaining == '0);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle sequencer: steps a single-cycle decoder/datapath through
// fetch, execute, memory access and writeback, handling valid/ready
// handshakes to instruction and data memory and turning register writes
// and PC updates into single-cycle strobes. Faults are sticky until reset.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   run                        start / continue execution
//   imem_req_*, imem_rsp_*     instruction memory handshake
//   imem_addr                  fetch address (= pc)
//   instruction                instruction register
//   pc, pc_next                current PC, next PC from datapath
//   dec_register_write_enable  decoder register write enable
//   dmem_req_*, dmem_rsp_valid data memory handshake
//   register_write_strobe      one-cycle register file write
//   halted, fault, fault_cause status
//   instret                    retired instruction count
//
// state      | meaning
// IDLE       | stopped, waiting for run
// FETCH_REQ  | instruction request held until accepted
// FETCH_WAIT | waiting for instruction data (watchdog running)
// EXECUTE    | decode/ALU settle cycle, opcode legality check
// MEM_REQ    | data request held until accepted
// MEM_WAIT   | waiting for load data / store ack (watchdog running)
// WRITEBACK  | retire: PC update, register write, alignment check
// FAULT      | sticky fault, left only by reset
module multicycle_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic        dec_register_write_enable,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_write,
  input  logic        dmem_rsp_valid,
  output logic        register_write_strobe,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] instret
);

  import seq_pkg::*;

  state_t      state, state_next;
  logic [6:0]  opcode;
  logic        misaligned;
  logic        wd_clear, wd_count, wd_expired;
  logic        load_instr, retire, set_cause;
  logic [1:0]  cause_next;

  assign opcode     = instruction[6:0];
  assign misaligned = (pc_next[1:0] != 2'b00);
  assign imem_addr  = pc;

  bus_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_bus_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= NOP;
      instret     <= '0;
      fault_cause <= CAUSE_NONE;
    end else begin
      state <= state_next;
      if (load_instr) instruction <= imem_rsp_data;
      if (retire) begin
        pc      <= pc_next;
        instret <= instret + 32'd1;
      end
      if (set_cause) fault_cause <= cause_next;
    end
  end

  always_comb begin
    state_next            = state;
    imem_req_valid        = 1'b0;
    dmem_req_valid        = 1'b0;
    dmem_req_write        = 1'b0;
    register_write_strobe = 1'b0;
    halted                = 1'b0;
    fault                 = 1'b0;
    wd_clear              = 1'b0;
    wd_count              = 1'b0;
    load_instr            = 1'b0;
    retire                = 1'b0;
    set_cause             = 1'b0;
    cause_next            = CAUSE_NONE;

    case (state)
      IDLE: begin
        halted = 1'b1;
        if (run) state_next = FETCH_REQ;
      end

      FETCH_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          wd_clear   = 1'b1;
          state_next = FETCH_WAIT;
        end
      end

      FETCH_WAIT: begin
        wd_count = 1'b1;
        // A response on the limit cycle still counts.
        if (imem_rsp_valid) begin
          load_instr = 1'b1;
          state_next = EXECUTE;
        end else if (wd_expired) begin
          set_cause  = 1'b1;
          cause_next = CAUSE_BUS_TIMEOUT;
          state_next = FAULT;
        end
      end

      EXECUTE: begin
        if (!is_legal_opcode(opcode)) begin
          set_cause  = 1'b1;
          cause_next = CAUSE_ILLEGAL;
          state_next = FAULT;
        end else if (is_mem_opcode(opcode)) begin
          state_next = MEM_REQ;
        end else begin
          state_next = WRITEBACK;
        end
      end

      MEM_REQ: begin
        dmem_req_valid = 1'b1;
        dmem_req_write = (opcode == OP_STORE);
        if (dmem_req_ready) begin
          wd_clear   = 1'b1;
          state_next = MEM_WAIT;
        end
      end

      MEM_WAIT: begin
        wd_count = 1'b1;
        if (dmem_rsp_valid) begin
          state_next = WRITEBACK;
        end else if (wd_expired) begin
          set_cause  = 1'b1;
          cause_next = CAUSE_BUS_TIMEOUT;
          state_next = FAULT;
        end
      end

      WRITEBACK: begin
        // A misaligned target aborts the retire entirely: no write, no PC move.
        if (misaligned) begin
          set_cause  = 1'b1;
          cause_next = CAUSE_MISALIGNED;
          state_next = FAULT;
        end else begin
          retire                = 1'b1;
          register_write_strobe = dec_register_write_enable;
          state_next            = run ? FETCH_REQ : IDLE;
        end
      end

      FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam logic [31:0] I_ADDI    = 32'h0050_0093;
  localparam logic [31:0] I_SW      = 32'h0011_2023;
  localparam logic [31:0] I_LW      = 32'h0001_2083;
  localparam logic [31:0] I_ILLEGAL = 32'h0000_007F;
  localparam logic [31:0] I_JAL     = 32'h0080_00EF;
  localparam logic [31:0] I_NOP     = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        dec_register_write_enable;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_write;
  logic        dmem_rsp_valid;
  logic        register_write_strobe;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] instret;

  multicycle_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .MEM_TIMEOUT (8)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .run                       (run),
    .imem_req_valid            (imem_req_valid),
    .imem_req_ready            (imem_req_ready),
    .imem_addr                 (imem_addr),
    .imem_rsp_valid            (imem_rsp_valid),
    .imem_rsp_data             (imem_rsp_data),
    .instruction               (instruction),
    .pc                        (pc),
    .pc_next                   (pc_next),
    .dec_register_write_enable (dec_register_write_enable),
    .dmem_req_valid            (dmem_req_valid),
    .dmem_req_ready            (dmem_req_ready),
    .dmem_req_write            (dmem_req_write),
    .dmem_rsp_valid            (dmem_rsp_valid),
    .register_write_strobe     (register_write_strobe),
    .halted                    (halted),
    .fault                     (fault),
    .fault_cause               (fault_cause),
    .instret                   (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath/decoder stand-ins: sequential PC unless an override targets a
  // given PC; stores are the only opcode that does not write a register.
  logic        pcn_override;
  logic [31:0] pcn_at;
  logic [31:0] pcn_value;
  assign pc_next = (pcn_override && (pc == pcn_at)) ? pcn_value : pc + 32'd4;
  assign dec_register_write_enable = (instruction[6:0] != 7'b0100011);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  // Scoreboard: each retire that should write a register is queued with the
  // instruction and the PC it executed at.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] at_pc;
  } exp_t;
  exp_t exp_q[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (register_write_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          timeout_fail("strobe_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("strobe_instr", instruction, e.instr);
          check("strobe_pc", pc, e.at_pc);
        end
      end
    end
  end

  // Memory models. imem: always ready, answers one cycle after acceptance.
  // dmem: ready after dmem_delay valid cycles, answers dmem_lat cycles
  // after acceptance (0 = never).
  logic [31:0] rom [logic [31:0]];
  int dmem_delay = 0;
  int dmem_lat   = 1;

  initial begin
    logic        imem_fire, dmem_fire, dmem_pending;
    logic [31:0] fire_addr;
    int          dmem_wait_cnt, dmem_rsp_cnt;
    imem_fire = 1'b0; dmem_fire = 1'b0; dmem_pending = 1'b0;
    fire_addr = '0; dmem_wait_cnt = 0; dmem_rsp_cnt = 0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = imem_fire;
      imem_rsp_data  = (imem_fire && rom.exists(fire_addr)) ? rom[fire_addr] : I_NOP;
      dmem_rsp_valid = 1'b0;
      if (dmem_fire && dmem_lat != 0) begin
        dmem_pending = 1'b1;
        dmem_rsp_cnt = 1;
      end else if (dmem_pending) begin
        dmem_rsp_cnt++;
      end
      if (dmem_pending && dmem_rsp_cnt == dmem_lat) begin
        dmem_rsp_valid = 1'b1;
        dmem_pending   = 1'b0;
      end
      if (!rst_n) dmem_pending = 1'b0;
      if (dmem_req_valid) begin
        dmem_req_ready = (dmem_wait_cnt >= dmem_delay);
        dmem_wait_cnt++;
      end else begin
        dmem_req_ready = 1'b0;
        dmem_wait_cnt  = 0;
      end
      imem_fire = imem_req_valid && imem_req_ready && rst_n;
      dmem_fire = dmem_req_valid && dmem_req_ready && rst_n;
      fire_addr = imem_addr;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_dmem_valid(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dmem_req_valid) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_halted(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (halted) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_fault(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fault) return;
    end
    timeout_fail(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int nvalid, nwait;
    logic wr_ok;
    pcn_override = 1'b0;
    pcn_at       = '0;
    pcn_value    = '0;
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_pc", pc, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    check("rst_instruction", instruction, I_NOP);
    check("rst_imem_valid", 32'(imem_req_valid), 32'd0);
    check("rst_dmem_valid", 32'(dmem_req_valid), 32'd0);

    // addi with zero-wait memory; run dropped during FETCH_WAIT
    rom.delete();
    rom[32'h0] = I_ADDI;
    rom[32'h4] = I_SW;
    rom[32'h8] = I_LW;
    exp_q.push_back('{instr: I_ADDI, at_pc: 32'h0});
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("c1_imem_valid", 32'(imem_req_valid), 32'd1);
        check("c1_imem_addr", imem_addr, 32'h0);
      end
      if (k == 2) run = 1'b0;
      if (k == 3) check("c3_instruction", instruction, I_ADDI);
      check($sformatf("addi_strobe_c%0d", k), 32'(register_write_strobe), (k == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("addi_pc", pc, 32'h4);
    check("addi_instret", instret, 32'd1);
    check("addi_idle_halted", 32'(halted), 32'd1);
    check("addi_idle_imem", 32'(imem_req_valid), 32'd0);

    // sw with dmem ready held low for 3 cycles
    dmem_delay = 3;
    dmem_lat   = 1;
    run = 1'b1;
    wait_dmem_valid("sw_wait_dmem");
    run = 1'b0;
    nvalid = 0;
    wr_ok  = 1'b1;
    while (dmem_req_valid && nvalid < 50) begin
      if (!dmem_req_write) wr_ok = 1'b0;
      nvalid++;
      @(negedge clk);
    end
    check("sw_valid_cycles", 32'(nvalid), 32'd4);
    check("sw_write", 32'(wr_ok), 32'd1);
    wait_halted("sw_wait_halt");
    check("sw_instret", instret, 32'd2);
    check("sw_pc", pc, 32'h8);
    check("sw_fault", 32'(fault), 32'd0);

    // lw with no data response: bus timeout after 8 MEM_WAIT cycles
    dmem_delay = 0;
    dmem_lat   = 0;
    run = 1'b1;
    wait_dmem_valid("lw_to_wait_dmem");
    run = 1'b0;
    nwait = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fault) break;
      nwait++;
    end
    check("to_wait_cycles", 32'(nwait), 32'd8);
    check("to_cause", 32'(fault_cause), 32'd1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_pc", pc, 32'h8);
    check("to_instret", instret, 32'd2);
    run = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("to_sticky_fault", 32'(fault), 32'd1);
      check("to_sticky_imem", 32'(imem_req_valid), 32'd0);
    end
    run = 1'b0;
    @(negedge clk);
    check("to_sticky_cause", 32'(fault_cause), 32'd1);

    // Illegal opcode
    dmem_lat = 1;
    do_reset();
    rom.delete();
    rom[32'h0] = I_ILLEGAL;
    run = 1'b1;
    wait_fault("ill_wait_fault");
    run = 1'b0;
    check("ill_cause", 32'(fault_cause), 32'd2);
    check("ill_pc", pc, 32'h0);
    check("ill_instret", instret, 32'd0);
    check("ill_instruction", instruction, I_ILLEGAL);

    // jal to a misaligned target after one good instruction
    do_reset();
    rom.delete();
    rom[32'h0] = I_ADDI;
    rom[32'h4] = I_JAL;
    pcn_override = 1'b1;
    pcn_at       = 32'h4;
    pcn_value    = 32'h0000_0102;
    exp_q.push_back('{instr: I_ADDI, at_pc: 32'h0});
    run = 1'b1;
    wait_fault("mis_wait_fault");
    run = 1'b0;
    check("mis_cause", 32'(fault_cause), 32'd3);
    check("mis_pc", pc, 32'h4);
    check("mis_instret", instret, 32'd1);
    check("mis_instruction", instruction, I_JAL);
    pcn_override = 1'b0;

    // Reset while a data request is pending
    do_reset();
    rom.delete();
    rom[32'h0] = I_ADDI;
    rom[32'h4] = I_LW;
    dmem_delay = 100;
    exp_q.push_back('{instr: I_ADDI, at_pc: 32'h0});
    run = 1'b1;
    wait_dmem_valid("rstmem_wait_dmem");
    check("rstmem_pre_pc", pc, 32'h4);
    check("rstmem_pre_instret", instret, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmem_dmem_valid", 32'(dmem_req_valid), 32'd0);
    check("rstmem_pc", pc, 32'h0);
    check("rstmem_instret", instret, 32'd0);
    rst_n = 1'b1;
    run   = 1'b0;
    dmem_delay = 0;
    repeat (2) @(negedge clk);

    // Load whose response lands on the watchdog limit cycle: no fault
    rom.delete();
    rom[32'h0] = I_LW;
    dmem_lat = 8;
    exp_q.push_back('{instr: I_LW, at_pc: 32'h0});
    run = 1'b1;
    wait_dmem_valid("lim_wait_dmem");
    run = 1'b0;
    wait_halted("lim_wait_halt");
    check("lim_fault", 32'(fault), 32'd0);
    check("lim_cause", 32'(fault_cause), 32'd0);
    check("lim_instret", instret, 32'd1);
    check("lim_pc", pc, 32'h4);

    repeat (2) @(negedge clk);
    check("strobes_outstanding", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- FSM that sequences the single-cycle control decoder and datapath over multiple clocks: fetch, execute, memory access, writeback.
- Handles valid/ready handshakes to instruction and data memory.
- Gates register/memory writes and the PC update into single-cycle strobes.
- Raises a sticky fault on bus timeout, illegal opcode or misaligned PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 255, max cycles spent in a wait state before a bus fault (must be >= 1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- run  in  1  start/continue execution.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  fetch request accepted.
- imem_addr  out  32  fetch address, always equal to pc.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction.
- instruction  out  32  instruction register; feeds the decoder and immediate generator.
- pc  out  32  current PC.
- pc_next  in  32  next PC from the datapath (already selected by pc_select).
- dec_register_write_enable  in  1  decoder register write enable.
- dmem_req_valid  out  1  data request.
- dmem_req_ready  in  1  data request accepted.
- dmem_req_write  out  1  1 = store, 0 = load.
- dmem_rsp_valid  in  1  data response; store acknowledge or load data valid.
- register_write_strobe  out  1  one-cycle register file write.
- halted  out  1  high in IDLE or FAULT.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  0 none, 1 bus timeout, 2 illegal opcode, 3 misaligned PC.
- instret  out  32  retired instruction count; wraps at 2^32.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, pc=RESET_PC, instruction=32'h0000_0013 (nop), instret=0, fault=0, fault_cause=0, watchdog=0.
  - All request and strobe outputs are 0 from the next cycle. Reset mid-transaction abandons it; the memories are reset on the same rst_n.
- Outputs are Moore (decoded from state), except register_write_strobe = (state==WRITEBACK) & dec_register_write_enable & no misalignment.
- IDLE: halted=1. If run, go to FETCH_REQ.
- FETCH_REQ:
  - imem_req_valid=1.
  - On imem_req_ready, go to FETCH_WAIT.
  - Valid is never withdrawn before ready; run is ignored here.
- FETCH_WAIT:
  - On imem_rsp_valid, instruction <= imem_rsp_data and go to EXECUTE.
  - A response in the same cycle as ready (in FETCH_REQ) is ignored; the memory responds no earlier than the next cycle.
- EXECUTE: one settle cycle for the combinational decode/ALU path.
  - opcode not in {0110011, 0010011, 1100111, 0110111, 0010111, 1101111, 0000011, 0100011}: go to FAULT, cause 2.
  - opcode 0000011 or 0100011: go to MEM_REQ.
  - Otherwise: go to WRITEBACK.
- MEM_REQ:
  - dmem_req_valid=1; dmem_req_write = (opcode==0100011).
  - Held until dmem_req_ready, then go to MEM_WAIT.
- MEM_WAIT: on dmem_rsp_valid (both loads and stores), go to WRITEBACK.
- WRITEBACK:
  - If pc_next[1:0]!=0: go to FAULT, cause 3. No strobe, pc unchanged, instret unchanged.
  - Else: pc <= pc_next, instret <= instret+1, strobe asserted per rule above. Then go to FETCH_REQ if run, else IDLE.
- FAULT: fault=1, halted=1. Held until reset; run is ignored.
- Watchdog:
  - Clears on entry to FETCH_WAIT or MEM_WAIT and increments each cycle in those states.
  - Reaching MEM_TIMEOUT without a response: go to FAULT, cause 1.
  - A response in the same cycle as the limit wins; no fault.
- Responses arriving in any state other than the matching wait state are ignored.
- Dropping run mid-instruction lets the current instruction retire, then the FSM goes to IDLE.
- Latency with zero-wait memory (ready in the request cycle, response the next cycle):
  - ALU/jump/U-type: 4 cycles per instruction.
  - Load/store: 6 cycles per instruction.

Decomposition:
- Package seq_pkg:
  - state enum (IDLE, FETCH_REQ, FETCH_WAIT, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, FAULT).
  - The 8 opcode constants.
  - Fault cause codes.
  - NOP constant 32'h0000_0013.
- Sub-module bus_watchdog:
  - Parameter MEM_TIMEOUT; counter width $clog2(MEM_TIMEOUT+1).
  - Inputs clk, rst_n, clear, count; output expired.

Test Plan:
- Reset, run=1, zero-wait memory, fetch 32'h0050_0093 (addi x1,x0,5), pc_next=4 → imem_req_valid in cycle 1; register_write_strobe high exactly in cycle 4; pc=4, instret=1.
- sw 32'h0011_2023, dmem_req_ready held low 3 cycles → dmem_req_valid high 4 consecutive cycles with dmem_req_write=1; register_write_strobe stays 0; instret increments by 1.
- MEM_TIMEOUT=8, lw 32'h0001_2083 with no dmem_rsp_valid → fault=1, fault_cause=1 after 8 MEM_WAIT cycles; halted=1; later run pulses have no effect.
- Fetch 32'h0000_007F → FAULT, fault_cause=2; no strobe; pc and instret unchanged.
- jal with pc_next=32'h0000_0102 → fault_cause=3; pc stays at the jal address; no register write.
- Deassert run during FETCH_WAIT → instruction retires, then IDLE with halted=1. Separately, rst_n low during MEM_REQ → next cycle dmem_req_valid=0, pc=RESET_PC, instret=0.
